main_mem_responder: RTL and testbench
=====================================

MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from read acceptance to the first response word; legal range 1..15.
REQ-002 Parameter BURST_LEN, default 8: words per read burst, equal to one cache block; power of two, 2..16.
REQ-003 Parameter ADDR_W, default 16: byte-address width; storage is 2^(ADDR_W-1) 16-bit words.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  request present this cycle.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_write  input  1  1 = single-word write, 0 = block read.
REQ-009 req_addr  input  ADDR_W  byte address; bit 0 ignored.
REQ-010 req_wdata  input  16  write data.
REQ-011 rsp_valid  output  1  rsp_data/rsp_addr valid this cycle.
REQ-012 rsp_data  output  16  read word.
REQ-013 rsp_addr  output  ADDR_W  byte address of rsp_data (bit 0 = 0).
REQ-014 rsp_last  output  1  final word of the burst.
REQ-015 busy  output  1  read in progress (state other than IDLE).

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and BURST.
REQ-017 In IDLE, req_ready=1; in WAIT and BURST, req_ready=0.
REQ-018 A request SHALL be accepted on the edge where req_valid & req_ready.
REQ-019 An accepted write SHALL store req_wdata at word index req_addr[ADDR_W-1:1] on that edge; FSM stays IDLE; no response is generated; a back-to-back write the next cycle SHALL be accepted.
REQ-020 An accepted read SHALL latch the block base (req_addr with the low log2(BURST_LEN)+1 bits cleared) and the start word offset, then enter WAIT with a latency counter loaded to LATENCY-1.
REQ-021 WAIT SHALL decrement the counter each cycle; when it is 0, the next state is BURST. The first rsp_valid occurs exactly LATENCY cycles after the acceptance edge.
REQ-022 BURST SHALL assert rsp_valid for exactly BURST_LEN consecutive cycles, one word per cycle, with no gaps and no backpressure.
REQ-023 The word offset SHALL increment modulo BURST_LEN each beat; rsp_addr = base + 2*offset and never leaves the block.
REQ-024 rsp_last SHALL be 1 only on beat BURST_LEN-1; the FSM returns to IDLE on the following edge, with req_ready=1 the cycle after rsp_last.
REQ-025 rsp_data SHALL reflect memory contents at the time of the beat; writes cannot occur during a read (req_ready=0).
REQ-026 When rsp_valid=0, rsp_data, rsp_addr and rsp_last SHALL be 0.
REQ-027 The memory array has no reset; unwritten words read as X in simulation.

Reset
REQ-028 When rst_n=0 at a rising edge, the FSM SHALL enter IDLE and the counter and offset SHALL clear to 0, with rsp_valid=0, rsp_last=0, rsp_data=0, rsp_addr=0, busy=0 and req_ready=1 from that edge.
REQ-029 Reset asserted during WAIT or BURST SHALL abort the burst with no further beats; memory contents are preserved.
REQ-030 A request presented in a cycle where rst_n=0 SHALL be ignored.

Configuration
REQ-031 Macro CRITICAL_WORD_FIRST_EN: when defined, the burst SHALL begin at the requested word (req_addr word offset) and wrap within the block; when undefined, every burst SHALL begin at offset 0 regardless of req_addr low bits.

Verification
REQ-032 Write 0x1111*k to byte addresses 0x0040+2k, for k=0..7, with back-to-back writes -> req_ready held 1 throughout and rsp_valid never asserted.
REQ-033 Read at 0x0040 with LATENCY=4 -> rsp_valid first asserted 4 cycles after acceptance; 8 beats with data 0x0000..0x7777, rsp_addr 0x0040..0x004E, rsp_last on the 8th beat, req_ready=1 the next cycle.
REQ-034 Read at 0x0046 -> with the macro: offsets 3,4,5,6,7,0,1,2 (rsp_addr 0x0046..0x004E, then 0x0040..0x0044); without the macro: offsets 0..7 starting at 0x0040.
REQ-035 req_valid held high with a read during BURST -> not accepted until IDLE; the second burst starts exactly LATENCY cycles after its acceptance.
REQ-036 rst_n=0 on the 3rd beat of a burst -> rsp_valid=0 from the reset edge with no further beats; a subsequent read of 0x0040 returns the original data.
REQ-037 Read at odd address 0x0041 -> identical response to a read at 0x0040.

Source files
------------

// File: rtl/main_mem_responder_if.sv
// Request/response bundle between a cache-side requester and the main memory responder.
// The requester (master) issues word writes and block reads; the responder (slave) returns bursts.
interface main_mem_responder_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_last;
    logic              busy;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, busy
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_last, busy
    );
endinterface

// File: rtl/main_mem_responder.sv
// Main memory model: single-word writes, fixed-latency block-read bursts (optional CRITICAL_WORD_FIRST_EN).
// Latency: first read beat LATENCY cycles after acceptance, then BURST_LEN back-to-back beats; writes take effect on acceptance.
// Backpressure: req_ready drops for the whole read; the burst itself cannot be stalled.
module main_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    main_mem_responder_if.slave   bus
);
    localparam int OFF_W = $clog2(BURST_LEN);
    localparam int BLK_W = ADDR_W - 1 - OFF_W;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [OFF_W-1:0]   offset;
    logic [OFF_W-1:0]   start_off;
    logic [BLK_W-1:0]   blk;
    logic               accept;
    logic               rd_accept;
    logic [15:0]        mem [2**(ADDR_W-1)];
    logic               unused_addr_lsb;

    assign unused_addr_lsb = bus.req_addr[0];

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_off = bus.req_addr[OFF_W:1];
`else
    assign start_off = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_last  = 1'b0;
        bus.busy      = 1'b1;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                // A request seen while reset is low must not touch memory or the FSM.
                accept        = bus.req_valid && rst_n;
                if (accept && !bus.req_write) state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = BURST;
            end
            BURST: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_last  = (cnt == 4'(BURST_LEN - 1));
                if (bus.rsp_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rd_accept = accept && !bus.req_write;

    // cnt counts down the access latency in WAIT, then counts beats up from 0 in BURST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            offset <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_accept) begin
                        cnt    <= 4'(LATENCY - 1);
                        offset <= start_off;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                BURST: begin
                    cnt    <= cnt + 4'd1;
                    offset <= offset + OFF_W'(1);
                end
                default: begin
                    cnt    <= 4'd0;
                    offset <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rd_accept) blk <= bus.req_addr[ADDR_W-1:OFF_W+1];
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_write) mem[bus.req_addr[ADDR_W-1:1]] <= bus.req_wdata;
    end

    assign bus.rsp_addr = bus.rsp_valid ? {blk, offset, 1'b0} : '0;
    assign bus.rsp_data = bus.rsp_valid ? mem[{blk, offset}] : 16'h0000;
endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized scoreboard bench for main_mem_responder: expected beats are queued at acceptance, a negedge monitor checks them.
module tb_main_mem_responder;
    localparam int LATENCY   = 4;
    localparam int BURST_LEN = 8;
    localparam int ADDR_W    = 16;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic        last;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    bit   mon_en = 1'b0;
    exp_t sbq[$];
    logic [15:0] ref_mem [int];

    main_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();

    main_mem_responder #(
        .LATENCY(LATENCY), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural expectation of one block read accepted at cycle acc.
    task automatic push_read(input logic [15:0] addr, input int acc);
        int base, start, off;
        exp_t e;
        base = int'(addr) & ~(2 * BURST_LEN - 1);
`ifdef CRITICAL_WORD_FIRST_EN
        start = (int'(addr) >> 1) % BURST_LEN;
`else
        start = 0;
`endif
        for (int i = 0; i < BURST_LEN; i++) begin
            off    = (start + i) % BURST_LEN;
            e.addr = 16'(base + 2 * off);
            e.data = ref_mem[int'(e.addr) >> 1];
            e.last = (i == BURST_LEN - 1);
            e.cyc  = acc + LATENCY + i;
            sbq.push_back(e);
        end
    endtask

    // Called #1 after a rising edge; holds the request until accepted.
    task automatic issue(input bit wr, input logic [15:0] addr, input logic [15:0] wd);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (!bus.req_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.req_ready) begin
            ncmp++; nfail++;
            $display("FAIL ready_timeout: req_ready got 0 required 1 within 200 cycles");
        end else begin
            @(posedge clk); #1;
            if (wr) ref_mem[int'(addr) >> 1] = wd;
            else    push_read(addr, cyc);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rsp_valid) begin
                if (sbq.size() == 0) begin
                    ncmp++; nfail++;
                    $display("FAIL unexpected_beat: got rsp_valid=1 addr 0x%0h required no beat", bus.rsp_addr);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("beat_data", bus.rsp_data, e.data);
                    chk("beat_addr", bus.rsp_addr, e.addr);
                    chk("beat_last", bus.rsp_last, e.last);
                    chk("beat_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_rsp_zero", {bus.rsp_data, bus.rsp_addr, bus.rsp_last}, 0);
            end
            chk("ready_vs_busy", bus.req_ready, !bus.busy);
        end
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset_ready", bus.req_ready, 1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known pattern block, back-to-back writes.
        for (int k = 0; k < 8; k++) begin
            chk("wr_burst_ready", bus.req_ready, 1);
            issue(1'b1, 16'(16'h0040 + 2 * k), 16'(16'h1111 * k));
        end

        // Fill the rest of 0x0000..0x01FF so every read returns defined data.
        for (int w = 0; w < 256; w++) begin
            if (w < 16'h20 || w >= 16'h28)
                issue(1'b1, 16'((2 * w) | $urandom_range(0, 1)), 16'($urandom));
        end

        // Directed reads, presented back to back so each waits out the previous burst.
        issue(1'b0, 16'h0040, 16'h0);
        issue(1'b0, 16'h0046, 16'h0);
        issue(1'b0, 16'h0041, 16'h0);
        drain();

        // Randomized mix of writes and reads within the filled region.
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                issue(1'b1, 16'($urandom_range(0, 16'h01FF)), 16'($urandom));
            else
                issue(1'b0, 16'($urandom_range(0, 16'h01FF)), 16'h0);
        end
        drain();

        // Restore the pattern block, then abort a burst with reset on its 3rd beat.
        for (int k = 0; k < 8; k++) issue(1'b1, 16'(16'h0040 + 2 * k), 16'(16'h1111 * k));
        issue(1'b0, 16'h0040, 16'h0);
        repeat (LATENCY + 2) @(posedge clk);
        #1;
        chk("abort_third_beat_valid", bus.rsp_valid, 1);
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0040;
        bus.req_wdata = 16'hDEAD;
        @(posedge clk); #1;
        sbq.delete();
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_ready", bus.req_ready, 1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b1;
        repeat (LATENCY + BURST_LEN) @(posedge clk);
        #1;
        issue(1'b0, 16'h0040, 16'h0);
        chk("post_reset_first_word", sbq[0].data, 16'h0000);
        drain();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
